posit_decoder: RTL
==================

// Module: posit_decoder
// PURPOSE
//  Bit-serial decoder for 32-bit posits with 3-bit exponent field (es=3); mirror of posit_encoder.
//  Unpacks posit_in into sign, signed regime k, exponent and left-aligned mantissa, one bit per clock.
//  Feeds the posit datapath. Its field encoding matches posit_encoder exactly.
//  Bit 31 is a plain sign flag: no two's-complement step.
// PARAMETERS
//  N   32  posit width; fixed, only value supported
//  ES  3   exponent field width; fixed, only value supported
//  KW  6   width of signed k; covers [-31,30]
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   asynchronous, active-low reset
//  start         in   1   sampled only in IDLE; latches posit_in
//  received      in   1   consumer ack; sampled only in COMPLETE
//  posit_in      in   32  posit word; must be valid in the start cycle only
//  sign_out      out  1   bit 31 of posit
//  k_out         out  6   signed regime value
//  exp_out       out  3   exponent, MSB first from the stream
//  mantissa_out  out  32  fraction bits, MSB at [31], zero-filled below
//  done          out  1   result valid; held until received
//  is_zero       out  1   special-case flag (POSIT_DEC_SPECIAL_EN), else tied 0
//  is_nar        out  1   special-case flag (POSIT_DEC_SPECIAL_EN), else tied 0
// BEHAVIOUR
//  - Reset (async, rst=0): all outputs 0, state IDLE, bit index 31, exp count 2, mantissa pointer 31.
//  - States: IDLE -> SIGN -> REGIME -> EXP -> MANT -> COMPLETE -> IDLE.
//  - IDLE:
//      - start=1: latch posit_in, clear all outputs, go to SIGN.
//      - start=0: hold done=0, stay in IDLE.
//  - SIGN: sign_out <= bit31; index <= 30.
//  - REGIME: r0 = bit30. Count the run m of bits equal to r0.
//      - Terminator is the first opposite bit; it is consumed.
//      - r0=1 gives k = m-1. r0=0 gives k = -m. The 6-bit counter must never overflow.
//  - EXP: 3 bits after the terminator go to exp_out[2], [1], [0] in that order.
//  - MANT: remaining bits go to mantissa_out[31], [30], ... down to stream bit 0.
//  - Truncation: any field cut off by bit 0 is zero-filled. Cases:
//      - 0x7FFF_FFFF: k=30, exp=0.
//      - 0x0000_0000: k=-31 with no terminator.
//  - Fixed latency: bits 30..0 take one cycle each, whatever the field split.
//      - FSM enters COMPLETE on the 32nd edge after the start edge.
//      - done rises on the 33rd edge.
//  - COMPLETE:
//      - done=1; outputs stable.
//      - Leave for IDLE only when received=1.
//      - done drops on the edge after IDLE is entered with start=0.
//  - start outside IDLE: ignored; no restart, no corruption.
//  - received outside COMPLETE: ignored.
//  - Reset mid-decode: immediate return to reset values; no partial result kept.
// CONFIGURATION
//  POSIT_DEC_SPECIAL_EN defined: in IDLE, if start=1 and posit_in[30:0]==0, skip to COMPLETE.
//      - 0x0000_0000: is_zero=1. 0x8000_0000: is_nar=1. sign_out=bit31; k/exp/mantissa all 0.
//      - done rises on the 2nd edge after the start edge.
//  Not defined: is_zero/is_nar tied 0; these two words decode serially as k=-31.
// STRUCTURE
//  Shared package posit_pkg:
//      - localparams N=32, ES=3, KW=6.
//      - FSM state encodings, shared with posit_encoder.
//  Sub-module posit_regime_cnt: run-length counter producing signed k plus a terminate strobe.
//  Everything else inline.
// TESTING
//  - 0x4000_0000 -> sign 0, k 0, exp 0, mant 0; done on 33rd edge after start.
//  - 0x5A00_0000 -> sign 0, k 0, exp 6, mant 0x8000_0000.
//  - 0x7FFF_FFFF -> k 30, exp 0, mant 0. 0x8000_0001 -> sign 1, k -30, exp 0, mant 0.
//  - 0x0000_0000 / 0x8000_0000, macro off -> k -31, done at 33 edges.
//      - Macro on -> is_zero / is_nar =1, done at 2 edges.
//  - Hold received=0 for 10 cycles -> done and outputs stable.
//      - Pulse start mid-decode -> ignored.
//      - rst=0 mid-decode -> all outputs 0 and state IDLE.
//  - Round trip with posit_encoder: feed decoder outputs to the encoder.
//      - Random legal posits must give p_hold == posit_in.

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit widths and FSM state encodings for posit_decoder/posit_encoder.
package posit_pkg;
  localparam int N = 32;
  localparam int ES = 3;
  localparam int KW = 6;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_REGIME,
    S_EXP,
    S_MANT,
    S_COMPLETE
  } state_t;
endpackage

// File: rtl/posit_regime_cnt.sv
// posit_regime_cnt: regime run-length counter; k includes the current bit when it extends the run.
module posit_regime_cnt
  import posit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 first,
  input  logic                 bit_in,
  output logic signed [KW-1:0] k,
  output logic                 term
);
  logic          r0;
  logic          run;
  logic          match;
  logic [KW-1:0] m;
  logic [KW-1:0] m_eff;
  always_comb begin
    run   = first ? bit_in : r0;
    match = first | (bit_in == r0);
    m_eff = match ? m + 1'b1 : m;
    k     = run ? signed'(m_eff - 1'b1) : signed'(-m_eff);
    term  = en & ~match;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0 <= 1'b0;
      m  <= '0;
    end else if (clr) begin
      m <= '0;
    end else if (en && match) begin
      m <= m_eff;
      if (first) r0 <= bit_in;
    end
  end
endmodule

// File: rtl/posit_decoder.sv
// posit_decoder: bit-serial posit<32,3> unpacker into sign, regime k, exponent and mantissa.
// Define POSIT_DEC_SPECIAL_EN to short-cut zero/NaR words and drive is_zero/is_nar.
module posit_decoder
  import posit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 received,
  input  logic [N-1:0]         posit_in,
  output logic                 sign_out,
  output logic signed [KW-1:0] k_out,
  output logic [ES-1:0]        exp_out,
  output logic [N-1:0]         mantissa_out,
  output logic                 done,
  output logic                 is_zero,
  output logic                 is_nar
);
  state_t               state, state_nxt;
  logic [N-1:0]         p;
  logic [4:0]           idx;
  logic [1:0]           ec;
  logic [4:0]           mp;
  logic                 cur;
  logic                 special;
  logic                 term;
  logic signed [KW-1:0] k;
  assign cur = p[idx];
`ifdef POSIT_DEC_SPECIAL_EN
  assign special = start && (posit_in[N-2:0] == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_zero <= 1'b0;
      is_nar  <= 1'b0;
    end else if (state == S_IDLE && start) begin
      is_zero <= special & ~posit_in[N-1];
      is_nar  <= special & posit_in[N-1];
    end
  end
`else
  assign special = 1'b0;
  assign is_zero = 1'b0;
  assign is_nar  = 1'b0;
`endif
  posit_regime_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == S_IDLE),
    .en    (state == S_REGIME),
    .first (idx == 5'd30),
    .bit_in(cur),
    .k     (k),
    .term  (term)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     state_nxt = start ? (special ? S_COMPLETE : S_SIGN) : S_IDLE;
      S_SIGN:     state_nxt = S_REGIME;
      S_REGIME:   state_nxt = (idx == 5'd0) ? S_COMPLETE : (term ? S_EXP : S_REGIME);
      S_EXP:      state_nxt = (idx == 5'd0) ? S_COMPLETE : ((ec == 2'd0) ? S_MANT : S_EXP);
      S_MANT:     state_nxt = (idx == 5'd0) ? S_COMPLETE : S_MANT;
      S_COMPLETE: state_nxt = received ? S_IDLE : S_COMPLETE;
      default:    state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p            <= '0;
      idx          <= 5'd31;
      ec           <= 2'd2;
      mp           <= 5'd31;
      sign_out     <= 1'b0;
      k_out        <= '0;
      exp_out      <= '0;
      mantissa_out <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            p            <= posit_in;
            idx          <= 5'd31;
            ec           <= 2'd2;
            mp           <= 5'd31;
            sign_out     <= special & posit_in[N-1];
            k_out        <= '0;
            exp_out      <= '0;
            mantissa_out <= '0;
          end
        end
        S_SIGN: begin
          sign_out <= p[N-1];
          idx      <= 5'd30;
        end
        S_REGIME: begin
          idx <= idx - 1'b1;
          if (term || idx == 5'd0) k_out <= k;
        end
        S_EXP: begin
          exp_out[ec] <= cur;
          ec          <= ec - 1'b1;
          idx         <= idx - 1'b1;
        end
        S_MANT: begin
          mantissa_out[mp] <= cur;
          mp               <= mp - 1'b1;
          idx              <= idx - 1'b1;
        end
        S_COMPLETE: done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
